// File: rtl/multi_edge_det_pkg.sv
// Shared encodings and legal parameter ranges for the multi-channel edge detector.
package multi_edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    localparam int CH_MIN      = 1;
    localparam int CH_MAX      = 32;
    localparam int SYNC_MIN    = 2;
    localparam int SYNC_MAX    = 4;
    localparam int STRETCH_MIN = 1;
    localparam int STRETCH_MAX = 16;
    localparam int CNT_W_MIN   = 1;
    localparam int CNT_W_MAX   = 16;

    function automatic bit in_range(int v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One detector channel: synchronizer, edge compare, pulse stretcher, sticky flag and
// saturating event counter.
module edge_det_ch
    import multi_edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             level,
    output logic             pulse,
    output logic             pend,
    output logic [CNT_W-1:0] cnt
);

    localparam int SW = $clog2(STRETCH + 1);
    localparam logic [SW-1:0] STRETCH_V = SW'(STRETCH);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [SW-1:0]          str_cnt;
    logic                   hit;
    logic                   evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];

    // Mode is applied here with no register so a mode change acts on the same cycle.
    always_comb begin
        hit = 1'b0;
        case (mode_e'(mode))
            MODE_RISE: hit = level & ~prev;
            MODE_FALL: hit = ~level & prev;
            MODE_BOTH: hit = level ^ prev;
            default:   hit = 1'b0;
        endcase
    end

    assign evt = en & hit;

    // pulse is its own flop; it stays high while the counter has more than one cycle left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            str_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            pulse <= evt | (str_cnt > SW'(1));
            if (evt)
                str_cnt <= STRETCH_V;
            else if (str_cnt != '0)
                str_cnt <= str_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else begin
            if (evt)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;

            if (clr)
                cnt <= evt ? CNT_W'(1) : '0;
            else if (evt && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_edge_det.sv
// CH independent edge detectors sharing one post-reset arm counter that masks
// detection until the synchronizers and prev hold real input history.
module multi_edge_det
    import multi_edge_det_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 1,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       d,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       pulse,
    output logic [CH-1:0]       pend,
    output logic [CH*CNT_W-1:0] cnt
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int AW      = $clog2(ARM_MAX + 1);

    generate
        if (!in_range(CH, CH_MIN, CH_MAX) ||
            !in_range(SYNC_STAGES, SYNC_MIN, SYNC_MAX) ||
            !in_range(STRETCH, STRETCH_MIN, STRETCH_MAX) ||
            !in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_param
            $error("multi_edge_det: parameter out of legal range");
        end
    endgenerate

    logic [AW-1:0] arm_cnt;
    logic          armed;

    assign armed = (arm_cnt == AW'(ARM_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            arm_cnt <= '0;
        else if (!armed)
            arm_cnt <= arm_cnt + 1'b1;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_det_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STRETCH     (STRETCH),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (armed),
            .d     (d[i]),
            .mode  (mode[2*i +: 2]),
            .clr   (clr[i]),
            .level (level[i]),
            .pulse (pulse[i]),
            .pend  (pend[i]),
            .cnt   (cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
